// File: rtl/bus_pkg.sv
// Shared types and constants for the local-bus arbiter and its address decoder.
package bus_pkg;

  localparam int unsigned BUS_AW = 20;
  localparam int unsigned BUS_DW = 8;

  localparam logic [BUS_DW-1:0] RD_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    T3,
    T4
  } State_t;

  // Transaction captured from the winning master for the length of one bus cycle
  typedef struct packed {
    logic              master;
    logic              we;
    logic              iom;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } txn_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address/IOM decode to one-hot chip selects; lowest device index wins on overlap.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int unsigned                NUM_DEV  = 2,
  parameter logic [NUM_DEV*BUS_AW-1:0] DEV_BASE = {20'h01C00, 20'h00000},
  parameter logic [NUM_DEV*BUS_AW-1:0] DEV_MASK = {20'hFF000, 20'hFFF00},
  parameter logic [NUM_DEV-1:0]        DEV_IOM  = 2'b10
) (
  input  logic [BUS_AW-1:0]  addr,
  input  logic               iom,
  output logic [NUM_DEV-1:0] cs_c,
  output logic               hit_c
);

  // Base bits outside the mask are ignored, so a base need not be mask-aligned.
  always_comb begin
    cs_c  = '0;
    hit_c = 1'b0;
    for (int unsigned k = 0; k < NUM_DEV; k++) begin
      if (!hit_c &&
          ((addr & DEV_MASK[k*BUS_AW +: BUS_AW]) ==
           (DEV_BASE[k*BUS_AW +: BUS_AW] & DEV_MASK[k*BUS_AW +: BUS_AW])) &&
          (iom == DEV_IOM[k])) begin
        cs_c[k] = 1'b1;
        hit_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// Two-master arbiter that runs one fixed T1-T4 local-bus cycle per grant and returns
// read data / write completion to the granted master.
module bus_cycle_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned                NUM_DEV     = 2,
  parameter logic [NUM_DEV*BUS_AW-1:0] DEV_BASE    = {20'h01C00, 20'h00000},
  parameter logic [NUM_DEV*BUS_AW-1:0] DEV_MASK    = {20'hFF000, 20'hFFF00},
  parameter logic [NUM_DEV-1:0]        DEV_IOM     = 2'b10,
  parameter int unsigned                M0_PRIORITY = 0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [1:0]          iom,
  input  logic [BUS_AW-1:0]   addr0,
  input  logic [BUS_AW-1:0]   addr1,
  input  logic [BUS_DW-1:0]   wdata0,
  input  logic [BUS_DW-1:0]   wdata1,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [BUS_DW-1:0]   rdata,
  output logic                decode_err,
  output logic [NUM_DEV-1:0]  CS,
  output logic                ALE,
  output logic                RD,
  output logic                WR,
  output logic                IOM,
  output logic [BUS_AW-1:0]   Address,
  inout  wire  [BUS_DW-1:0]   Data
);

  State_t state_q, state_d;
  txn_t   txn_q, txn_d;
  logic   ptr_q, ptr_d;
  logic   hit_q, hit_d;
  logic   data_oe;
  logic   win_c;

  logic [1:0]         gnt_d, done_d;
  logic [BUS_DW-1:0]  rdata_d;
  logic               derr_d, ale_d, rd_d, wr_d, iom_d, oe_d;
  logic [NUM_DEV-1:0] cs_d;
  logic [BUS_AW-1:0]  addr_d;

  logic [NUM_DEV-1:0] dec_cs_c;
  logic               dec_hit_c;

  // Decode the transaction being latched so CS is registered in time for T1.
  bus_addr_decode #(
    .NUM_DEV (NUM_DEV),
    .DEV_BASE(DEV_BASE),
    .DEV_MASK(DEV_MASK),
    .DEV_IOM (DEV_IOM)
  ) u_decode (
    .addr (txn_d.addr),
    .iom  (txn_d.iom),
    .cs_c (dec_cs_c),
    .hit_c(dec_hit_c)
  );

  // ptr_q names the master preferred on a tie in round-robin mode.
  always_comb begin
    if (M0_PRIORITY != 0) begin
      win_c = ~req[0];
    end else if (req == 2'b11) begin
      win_c = ptr_q;
    end else begin
      win_c = ~req[0];
    end
  end

  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    ptr_d   = ptr_q;
    hit_d   = hit_q;
    gnt_d   = '0;
    done_d  = '0;
    rdata_d = rdata;
    derr_d  = 1'b0;
    cs_d    = '0;
    ale_d   = 1'b0;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    iom_d   = 1'b0;
    addr_d  = '0;
    oe_d    = 1'b0;

    unique case (state_q)
      IDLE, T4: begin
        if (req != 2'b00) begin
          state_d     = T1;
          txn_d.master = win_c;
          txn_d.we     = we[win_c];
          txn_d.iom    = iom[win_c];
          txn_d.addr   = win_c ? addr1 : addr0;
          txn_d.wdata  = win_c ? wdata1 : wdata0;
        end else begin
          state_d = IDLE;
        end
      end
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3:      state_d = T4;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are computed for the state being entered.
    unique case (state_d)
      T1: begin
        gnt_d  = txn_d.master ? 2'b10 : 2'b01;
        ale_d  = 1'b1;
        cs_d   = dec_cs_c;
        hit_d  = dec_hit_c;
        iom_d  = txn_d.iom;
        addr_d = txn_d.addr;
      end
      T2, T3: begin
        gnt_d  = txn_d.master ? 2'b10 : 2'b01;
        cs_d   = CS;
        iom_d  = txn_d.iom;
        addr_d = txn_d.addr;
        rd_d   = txn_d.we;
        wr_d   = ~txn_d.we;
        oe_d   = txn_d.we;
      end
      T4: begin
        gnt_d  = txn_d.master ? 2'b10 : 2'b01;
        done_d = txn_d.master ? 2'b10 : 2'b01;
        cs_d   = CS;
        iom_d  = txn_d.iom;
        addr_d = txn_d.addr;
        derr_d = ~hit_q;
        ptr_d  = ~txn_d.master;
        if (!txn_d.we) begin
          rdata_d = hit_q ? Data : RD_DEFAULT;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      txn_q      <= '0;
      ptr_q      <= 1'b0;
      hit_q      <= 1'b0;
      gnt        <= '0;
      done       <= '0;
      rdata      <= '0;
      decode_err <= 1'b0;
      CS         <= '0;
      ALE        <= 1'b0;
      RD         <= 1'b1;
      WR         <= 1'b1;
      IOM        <= 1'b0;
      Address    <= '0;
      data_oe    <= 1'b0;
    end else begin
      state_q    <= state_d;
      txn_q      <= txn_d;
      ptr_q      <= ptr_d;
      hit_q      <= hit_d;
      gnt        <= gnt_d;
      done       <= done_d;
      rdata      <= rdata_d;
      decode_err <= derr_d;
      CS         <= cs_d;
      ALE        <= ale_d;
      RD         <= rd_d;
      WR         <= wr_d;
      IOM        <= iom_d;
      Address    <= addr_d;
      data_oe    <= oe_d;
    end
  end

  assign Data = data_oe ? txn_q.wdata : {BUS_DW{1'bz}};

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Bench for bus_cycle_arbiter: round-robin and fixed-priority instances share stimulus and are
// checked every cycle against a transaction-queue model, plus literal pins for key scenarios.
module tb_bus_cycle_arbiter;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        derr;
    logic [1:0]  cs;
    logic        ale;
    logic        rd;
    logic        wr;
    logic        iom;
    logic [19:0] address;
    logic        drive;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } exp_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        derr;
    logic [1:0]  cs;
    logic        ale;
    logic        rd;
    logic        wr;
    logic        iom;
    logic [19:0] address;
    logic [7:0]  data;
    logic [7:0]  rdata;
  } obs_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  req, we, iom;
  logic [19:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;

  int errors = 0;
  int checks = 0;

  initial forever #5 CLK = ~CLK;

  // Reference device map: device 0 = IO 000xx, device 1 = memory 01xxx; first match wins.
  function automatic logic [1:0] ref_cs(input logic [19:0] a, input logic io);
    logic [19:0] base [2];
    logic [19:0] mask [2];
    logic        mio  [2];
    base = '{20'h00000, 20'h01C00};
    mask = '{20'hFFF00, 20'hFF000};
    mio  = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      if (((a & mask[k]) == (base[k] & mask[k])) && (io == mio[k])) return 2'(1 << k);
    end
    return 2'b00;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [1:0]  gnt, done, cs;
    logic [7:0]  rdata;
    logic        derr, ale, rd, wr, iom_o;
    logic [19:0] address;
    wire  [7:0]  data;
    obs_t        obs;

    bus_cycle_arbiter #(
      .NUM_DEV    (2),
      .DEV_BASE   ({20'h01C00, 20'h00000}),
      .DEV_MASK   ({20'hFF000, 20'hFFF00}),
      .DEV_IOM    (2'b10),
      .M0_PRIORITY(g)
    ) u_dut (
      .CLK(CLK), .RESET(RESET), .req(req), .we(we), .iom(iom),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt(gnt), .done(done), .rdata(rdata), .decode_err(derr), .CS(cs),
      .ALE(ale), .RD(rd), .WR(wr), .IOM(iom_o), .Address(address), .Data(data)
    );

    // Selected device answers a read with the low address byte XOR A0.
    assign data = (!rd && (cs != 2'b00)) ? (address[7:0] ^ 8'hA0) : 8'hzz;
    assign obs  = {gnt, done, derr, cs, ale, rd, wr, iom_o, address, data, rdata};

    exp_t       cur;
    exp_t       q[$];
    logic       valid   = 1'b0;
    logic       pref    = 1'b0;
    logic [7:0] rd_hold = 8'h00;

    // Model: a granted transaction expands into four per-cycle expectations.
    always @(posedge CLK) begin
      exp_t        e;
      logic        m, w, io;
      logic [19:0] a;
      logic [7:0]  wd, rdv;
      logic [1:0]  csx;
      valid = 1'b1;
      if (RESET) begin
        q.delete();
        pref    = 1'b0;
        rd_hold = 8'h00;
        e       = '0;
        e.rd    = 1'b1;
        e.wr    = 1'b1;
        cur     = e;
      end else begin
        if (q.size() == 0 && req != 2'b00) begin
          if (g == 1 || req != 2'b11) m = req[0] ? 1'b0 : 1'b1;
          else                       m = pref;
          pref = ~m;
          a    = m ? addr1 : addr0;
          wd   = m ? wdata1 : wdata0;
          w    = we[m];
          io   = iom[m];
          csx  = ref_cs(a, io);
          rdv  = (csx != 2'b00) ? (a[7:0] ^ 8'hA0) : 8'hFF;
          for (int p = 1; p <= 4; p++) begin
            e         = '0;
            e.gnt     = m ? 2'b10 : 2'b01;
            e.cs      = csx;
            e.iom     = io;
            e.address = a;
            e.rd      = 1'b1;
            e.wr      = 1'b1;
            e.rdata   = rd_hold;
            if (p == 1) e.ale = 1'b1;
            if (p == 2 || p == 3) begin
              e.rd    = w;
              e.wr    = ~w;
              e.drive = w;
              e.wdata = wd;
            end
            if (p == 4) begin
              e.done = e.gnt;
              e.derr = (csx == 2'b00);
              if (!w) e.rdata = rdv;
            end
            q.push_back(e);
          end
          if (!w) rd_hold = rdv;
        end
        if (q.size() > 0) begin
          cur = q.pop_front();
        end else begin
          e       = '0;
          e.rd    = 1'b1;
          e.wr    = 1'b1;
          e.rdata = rd_hold;
          cur     = e;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input obs_t o);
    chk({nm, ".gnt"},        32'(o.gnt),     32'(e.gnt));
    chk({nm, ".done"},       32'(o.done),    32'(e.done));
    chk({nm, ".decode_err"}, 32'(o.derr),    32'(e.derr));
    chk({nm, ".CS"},         32'(o.cs),      32'(e.cs));
    chk({nm, ".ALE"},        32'(o.ale),     32'(e.ale));
    chk({nm, ".RD"},         32'(o.rd),      32'(e.rd));
    chk({nm, ".WR"},         32'(o.wr),      32'(e.wr));
    chk({nm, ".IOM"},        32'(o.iom),     32'(e.iom));
    chk({nm, ".Address"},    32'(o.address), 32'(e.address));
    chk({nm, ".rdata"},      32'(o.rdata),   32'(e.rdata));
    if (e.drive) chk({nm, ".Data"}, 32'(o.data), 32'(e.wdata));
  endtask

  // One clock: advance, then compare both instances against the model away from the edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    if (g_inst[0].valid) cmp("rr", g_inst[0].cur, g_inst[0].obs);
    if (g_inst[1].valid) cmp("fp", g_inst[1].cur, g_inst[1].obs);
  endtask

  function automatic logic [19:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return 20'h01C00 | 20'($urandom_range(0, 1023));
      1:       return 20'($urandom_range(0, 255));
      default: return 20'($urandom);
    endcase
  endfunction

  initial begin
    RESET = 1'b1; req = 2'b00; we = 2'b00; iom = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tick(); tick();
    chk("reset.RD",    32'(g_inst[0].rd),    32'h1);
    chk("reset.gnt",   32'(g_inst[0].gnt),   32'h0);
    chk("reset.rdata", 32'(g_inst[0].rdata), 32'h0);
    chk("reset.CS",    32'(g_inst[0].cs),    32'h0);
    RESET = 1'b0;
    tick();

    // M0 memory read at 01C05
    req = 2'b01; we = 2'b00; iom = 2'b01; addr0 = 20'h01C05;
    tick();
    chk("m0rd.T1.ALE", 32'(g_inst[0].ale), 32'h1);
    chk("m0rd.T1.CS",  32'(g_inst[0].cs),  32'h2);
    chk("m0rd.T1.gnt", 32'(g_inst[0].gnt), 32'h1);
    req = 2'b00;
    tick();
    chk("m0rd.T2.ALE", 32'(g_inst[0].ale), 32'h0);
    chk("m0rd.T2.RD",  32'(g_inst[0].rd),  32'h0);
    tick();
    chk("m0rd.T3.RD",  32'(g_inst[0].rd),  32'h0);
    tick();
    chk("m0rd.T4.done",  32'(g_inst[0].done),  32'h1);
    chk("m0rd.T4.rdata", 32'(g_inst[0].rdata), 32'hA5);
    tick();

    // M0 memory read with no device hit
    req = 2'b01; addr0 = 20'hF0000;
    tick();
    chk("nohit.T1.CS", 32'(g_inst[0].cs), 32'h0);
    req = 2'b00;
    tick(); tick(); tick();
    chk("nohit.T4.derr",  32'(g_inst[0].derr),  32'h1);
    chk("nohit.T4.done",  32'(g_inst[0].done),  32'h1);
    chk("nohit.T4.rdata", 32'(g_inst[0].rdata), 32'hFF);
    tick();

    // M1 IO write of 3C to 00010
    req = 2'b10; we = 2'b10; iom = 2'b00; addr1 = 20'h00010; wdata1 = 8'h3C;
    tick();
    chk("m1wr.T1.CS",  32'(g_inst[0].cs),  32'h1);
    chk("m1wr.T1.gnt", 32'(g_inst[0].gnt), 32'h2);
    req = 2'b00;
    tick();
    chk("m1wr.T2.WR",   32'(g_inst[0].wr),   32'h0);
    chk("m1wr.T2.Data", 32'(g_inst[0].data), 32'h3C);
    tick();
    chk("m1wr.T3.Data", 32'(g_inst[0].data), 32'h3C);
    tick();
    chk("m1wr.T4.done", 32'(g_inst[0].done), 32'h2);
    chk("m1wr.T4.WR",   32'(g_inst[0].wr),   32'h1);
    tick();

    // Both masters continuously requesting
    req = 2'b11; we = 2'b10; iom = 2'b01; addr0 = 20'h01C10; addr1 = 20'h00020; wdata1 = 8'h5A;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 1 || t == 9) chk("rr.gnt.m0", 32'(g_inst[0].gnt), 32'h1);
      if (t == 5)           chk("rr.gnt.m1", 32'(g_inst[0].gnt), 32'h2);
      if (t == 5)           chk("rr.nogap.ALE", 32'(g_inst[0].ale), 32'h1);
      if (t == 1 || t == 5 || t == 9) chk("fp.gnt.m0", 32'(g_inst[1].gnt), 32'h1);
    end
    req = 2'b00;
    tick();

    // Reset during T3 of an M0 memory write
    req = 2'b01; we = 2'b01; iom = 2'b01; addr0 = 20'h01C33; wdata0 = 8'h77;
    tick();
    req = 2'b00;
    tick(); tick();
    chk("rstwr.T3.WR",   32'(g_inst[0].wr),   32'h0);
    chk("rstwr.T3.Data", 32'(g_inst[0].data), 32'h77);
    RESET = 1'b1;
    tick();
    chk("rstwr.WR",   32'(g_inst[0].wr),   32'h1);
    chk("rstwr.CS",   32'(g_inst[0].cs),   32'h0);
    chk("rstwr.done", 32'(g_inst[0].done), 32'h0);
    chk("rstwr.gnt",  32'(g_inst[0].gnt),  32'h0);
    RESET = 1'b0;
    tick(); tick();

    // Randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      RESET  = ($urandom_range(0, 99) == 0);
      req    = 2'($urandom_range(0, 3));
      we     = 2'($urandom);
      iom    = 2'($urandom);
      addr0  = rand_addr();
      addr1  = rand_addr();
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      tick();
    end
    RESET = 1'b0; req = 2'b00;
    for (int n = 0; n < 6; n++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
